fp_unit_arbiter: RTL

- Shares one pipelined two-operand floating-point unit (adder/multiplier core with `fp_a_i`/`fp_b_i`/`valid_i` in and `fp_o`/`valid_o` out, fixed latency, no backpressure) between N requesters.
- Round-robin grant; ready/valid on the requester side; registered issue into the unit.
- A tag shift register routes each result back to the requester that issued it.
- Also checks that the unit's `valid_o` timing matches expectations, and drains stray results after reset.

---
 rtl/fp_unit_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined FP unit between NUM_REQ requesters.
// Optional per-requester saturating grant counters when FP_UNIT_ARBITER_STATS_EN is defined.
module fp_unit_arbiter #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 3,
    localparam int FP_W = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*FP_W-1:0] req_a_i,
    input  logic [NUM_REQ*FP_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [FP_W-1:0]         fpu_a_o,
    output logic [FP_W-1:0]         fpu_b_o,
    output logic                    fpu_valid_o,
    input  logic [FP_W-1:0]         fpu_result_i,
    input  logic                    fpu_valid_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [FP_W-1:0]         rsp_data_o,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic                    err_o
`ifdef FP_UNIT_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   stat_grants_o
`endif
);

    localparam logic [0:0] ST_DRAIN = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam int         CNT_W    = $clog2(FPU_LATENCY + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [ID_W-1:0]  ptr_q;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand_id;
    int               cand;
    logic             xfer;
    logic [FP_W-1:0]  sel_a;
    logic [FP_W-1:0]  sel_b;

    logic [FP_W-1:0]  fpu_a_q, fpu_b_q;
    logic             fpu_valid_q;

    // Stage i holds the tag of the op whose result is expected i cycles later than issue.
    logic [FPU_LATENCY:0] tag_vld_q;
    logic [ID_W-1:0]      tag_id_q [FPU_LATENCY+1];
    logic                 tail_vld;
    logic [ID_W-1:0]      tail_id;

    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [FP_W-1:0]      rsp_data_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic                 err_q;

    // Leftover unit outputs from before reset are swallowed for FPU_LATENCY cycles.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (state_q == ST_DRAIN) begin
            drain_cnt_d = drain_cnt_q - CNT_W'(1);
            if (drain_cnt_q == CNT_W'(1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        cand_id     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand    = (int'(ptr_q) + i) % NUM_REQ;
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid_i[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    assign xfer  = (state_q == ST_RUN) && grant_found;
    assign sel_a = req_a_i[grant_id*FP_W +: FP_W];
    assign sel_b = req_b_i[grant_id*FP_W +: FP_W];

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign tail_vld = tag_vld_q[FPU_LATENCY];
    assign tail_id  = tag_id_q[FPU_LATENCY];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= CNT_W'(FPU_LATENCY);
            ptr_q       <= ID_W'(NUM_REQ - 1);
            fpu_valid_q <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            fpu_valid_q <= xfer;
            if (xfer) begin
                ptr_q   <= grant_id;
                fpu_a_q <= sel_a;
                fpu_b_q <= sel_b;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tag_vld_q <= '0;
            for (int i = 0; i <= FPU_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= xfer;
            tag_id_q[0]  <= grant_id;
            for (int i = 1; i <= FPU_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // A result without a tag, or a tag without a result, means the unit's latency is not what we assume.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (tail_vld && fpu_valid_i) begin
                rsp_valid_q[tail_id] <= 1'b1;
                rsp_data_q           <= fpu_result_i;
                rsp_id_q             <= tail_id;
            end
            if ((tail_vld && !fpu_valid_i) ||
                (!tail_vld && fpu_valid_i && state_q == ST_RUN)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fpu_a_o     = fpu_a_q;
    assign fpu_b_o     = fpu_b_q;
    assign fpu_valid_o = fpu_valid_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign err_o       = err_q;

`ifdef FP_UNIT_ARBITER_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [15:0] grant_cnt_q;
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    grant_cnt_q <= '0;
                end else if (xfer && grant_id == ID_W'(gi) && grant_cnt_q != 16'hFFFF) begin
                    grant_cnt_q <= grant_cnt_q + 16'd1;
                end
            end
            assign stat_grants_o[gi*16 +: 16] = grant_cnt_q;
        end
    endgenerate
`endif

endmodule
